// File: rtl/uart_tx_buffered_if.sv
// Byte handshake between a producer and the buffered UART transmitter.
// Latency: none, this only bundles wires.
// Backpressure: the producer holds VALID/DATA until READY is high on a rising edge.
interface uart_tx_buffered_if;
  logic [7:0] DATA;
  logic       VALID;
  logic       READY;

  // Producer side: offers bytes and watches READY.
  modport master (output DATA, output VALID, input READY);
  // Transmitter side: takes bytes and advertises room.
  modport slave  (input DATA, input VALID, output READY);
endinterface

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a FIFO_DEPTH-entry byte FIFO.
// Latency: a byte pushed into an idle, empty block on edge k drives TX low after edge k+1.
// Backpressure: READY drops when the FIFO holds FIFO_DEPTH bytes; a full FIFO refuses pushes.
module uart_tx_buffered #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                              CLK,
  input  logic                              RSTN,
  uart_tx_buffered_if.slave                 bus,
  output logic                              TX,
  output logic                              BUSY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   COUNT
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLK_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  logic            push, pop, fifo_nonempty, baud_end;

  // Room is judged from the registered count only, so a pop never frees a slot in its own cycle.
  assign bus.READY     = (count_q != CW'(FIFO_DEPTH));
  assign push          = bus.VALID && bus.READY;
  assign fifo_nonempty = (count_q != '0);
  assign baud_end      = (baud_q == BW'(CLK_PER_BIT - 1));
  // The serializer takes a new byte when idle or at the last cycle of a stop bit.
  assign pop           = fifo_nonempty &&
                         ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_end));

  assign TX    = tx_q;
  assign BUSY  = (state_q != S_IDLE) || fifo_nonempty;
  assign COUNT = count_q;

  // FIFO storage; contents need no reset because the count guards every read.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= bus.DATA;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Serializer state and datapath registers; reset forces the line idle at once.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state: frame sequencing, chaining straight into a new start bit when bytes wait.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fifo_nonempty) state_d = S_START;
      S_START: if (baud_end) state_d = S_DATA;
      S_DATA:  if (baud_end && (bit_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (baud_end) state_d = fifo_nonempty ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: baud timing, bit index, shift register and the registered line level.
  always_comb begin
    baud_d  = baud_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (pop) begin
          shift_d = mem[rd_ptr_q];
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_end) begin
          bit_d = '0;
          tx_d  = shift_q[0];
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (baud_end) begin
          if (pop) begin
            shift_d = mem[rd_ptr_q];
            tx_d    = 1'b0;
          end else begin
            tx_d = 1'b1;
          end
        end
      end
      default: begin
        baud_d = '0;
        tx_d   = 1'b1;
      end
    endcase
  end

endmodule
